// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 10;

    // Arbiter sequencing: issue slot free, or a read is in flight.
    typedef enum logic {
        IDLE,
        READ_WAIT
    } arb_state_t;

    // Which requester the outstanding read belongs to.
    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

    // 4-bit increment that sticks at lim once reached.
    function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] lim);
        return (value >= lim) ? lim : value + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Host starvation guard: counts CPU issues that overtook a waiting host
// and raises host_priority once MAX_WAIT of them have happened in a row.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic host_req,
    input  logic host_gnt,
    input  logic cpu_issue,
    output logic host_priority
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Clear when the host is served or stops asking; otherwise count CPU overtakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (host_gnt || !host_req) begin
            wait_cnt <= '0;
        end else if (cpu_issue) begin
            wait_cnt <= sat_inc4(wait_cnt, WAIT_LIMIT);
        end
    end

    assign host_priority = (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between the memory stage (CPU) and
// the host/loader port. One access per issue slot; reads hold the slot
// until the RAM returns data READ_LAT cycles later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    output logic              cpuStall,
    output logic              cpuRvalid,
    output logic [DATA_W-1:0] cpuRdata,
    input  logic              hostReq,
    input  logic              hostWe,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWdata,
    output logic              hostGnt,
    output logic              hostRvalid,
    output logic [DATA_W-1:0] hostRdata,
    output logic              ramEn,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWdata,
    input  logic [DATA_W-1:0] ramRdata
);

    localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

    arb_state_t        state;
    owner_t            owner;
    logic [2:0]        lat_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    logic host_win;
    logic cpu_win;
    logic rd_done;
    logic host_priority;

    arb_starve_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk           (clk),
        .reset         (reset),
        .host_req      (hostReq),
        .host_gnt      (host_win),
        .cpu_issue     (cpu_win),
        .host_priority (host_priority)
    );

    // Pick this cycle's winner and detect read completion; nothing moves during reset.
    always_comb begin
        host_win = 1'b0;
        cpu_win  = 1'b0;
        rd_done  = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                host_win = hostReq && (!cpuReq || host_priority);
                cpu_win  = cpuReq && !host_win;
            end else begin
                rd_done = (lat_cnt == 3'd1);
            end
        end
    end

    // Steer the winner's request fields onto the RAM port in the issue cycle.
    always_comb begin
        ramEn    = host_win || cpu_win;
        ramWe    = 1'b0;
        ramAddr  = '0;
        ramWdata = '0;
        if (host_win) begin
            ramWe    = hostWe;
            ramAddr  = hostAddr;
            ramWdata = hostWdata;
        end else if (cpu_win) begin
            ramWe    = cpuWe;
            ramAddr  = cpuAddr;
            ramWdata = cpuWdata;
        end
    end

    // Completion pulses, read-data pass-through and memory-stage stall.
    always_comb begin
        hostGnt    = host_win;
        cpuRvalid  = rd_done && (owner == OWN_CPU);
        hostRvalid = rd_done && (owner == OWN_HOST);
        if (reset) begin
            cpuRdata  = '0;
            hostRdata = '0;
        end else begin
            cpuRdata  = cpuRvalid  ? ramRdata : cpu_rdata_q;
            hostRdata = hostRvalid ? ramRdata : host_rdata_q;
        end
        cpuStall = cpuReq && !((cpu_win && cpuWe) || cpuRvalid);
    end

    // Slot sequencer: a read parks here until its data returns; reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OWN_CPU;
            lat_cnt      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ramEn && !ramWe) begin
                        state   <= READ_WAIT;
                        lat_cnt <= LAT_INIT;
                        owner   <= host_win ? OWN_HOST : OWN_CPU;
                    end
                end
                READ_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (rd_done) begin
                        state <= IDLE;
                    end
                    if (cpuRvalid) begin
                        cpu_rdata_q <= ramRdata;
                    end
                    if (hostRvalid) begin
                        host_rdata_q <= ramRdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-numbered
// transaction model with a golden memory image.
module tb_mem_port_arbiter;

    localparam int DW = 24;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int MW = 4;

    logic          clk;
    logic          reset;
    logic          cpuReq, cpuWe, cpuStall, cpuRvalid;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata, cpuRdata;
    logic          hostReq, hostWe, hostGnt, hostRvalid;
    logic [AW-1:0] hostAddr;
    logic [DW-1:0] hostWdata, hostRdata;
    logic          ramEn, ramWe;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWdata, ramRdata;

    mem_port_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .READ_LAT (RL),
        .MAX_WAIT (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpuReq     (cpuReq),
        .cpuWe      (cpuWe),
        .cpuAddr    (cpuAddr),
        .cpuWdata   (cpuWdata),
        .cpuStall   (cpuStall),
        .cpuRvalid  (cpuRvalid),
        .cpuRdata   (cpuRdata),
        .hostReq    (hostReq),
        .hostWe     (hostWe),
        .hostAddr   (hostAddr),
        .hostWdata  (hostWdata),
        .hostGnt    (hostGnt),
        .hostRvalid (hostRvalid),
        .hostRdata  (hostRdata),
        .ramEn      (ramEn),
        .ramWe      (ramWe),
        .ramAddr    (ramAddr),
        .ramWdata   (ramWdata),
        .ramRdata   (ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with fixed read latency; junk on the data bus when no read matures.
    logic [DW-1:0] ram_mem [0:1023];
    logic [DW-1:0] rd_pipe [0:RL-1];

    always @(posedge clk) begin
        if (ramEn && ramWe) ram_mem[ramAddr] <= ramWdata;
        rd_pipe[0] <= (ramEn && !ramWe) ? ram_mem[ramAddr] : DW'($urandom);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ramRdata = rd_pipe[RL-1];

    // Pending requester intent, applied to the DUT at the next falling edge.
    logic          rst, cr, cw, hr, hw;
    logic [AW-1:0] ca, ha;
    logic [DW-1:0] cd, hd;

    // Reference model state.
    int            cyc;
    bit            m_busy, m_rd_host;
    int            m_done_cyc;
    logic [AW-1:0] m_rd_addr;
    int            m_starve;
    logic [DW-1:0] golden [0:1023];
    logic [DW-1:0] m_last_c, m_last_h;
    bit            cpu_done, host_done;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: apply intent, compare outputs with the model, advance the model.
    task automatic step();
        bit            host_go, cpu_go, rv_c, rv_h, e_stall;
        logic [DW-1:0] e_rc, e_rh;
        @(negedge clk);
        reset = rst; cpuReq = cr; cpuWe = cw; cpuAddr = ca; cpuWdata = cd;
        hostReq = hr; hostWe = hw; hostAddr = ha; hostWdata = hd;
        #1;
        host_go = 0; cpu_go = 0; rv_c = 0; rv_h = 0;
        if (!rst) begin
            if (m_busy) begin
                if (cyc == m_done_cyc) begin
                    rv_c = !m_rd_host;
                    rv_h = m_rd_host;
                end
            end else begin
                host_go = hr && (!cr || m_starve >= MW);
                cpu_go  = cr && !host_go;
            end
        end
        e_rc    = rst ? '0 : (rv_c ? golden[m_rd_addr] : m_last_c);
        e_rh    = rst ? '0 : (rv_h ? golden[m_rd_addr] : m_last_h);
        e_stall = cr && !((cpu_go && cw) || rv_c);

        check("ramEn",      32'(ramEn),      32'(host_go || cpu_go));
        check("hostGnt",    32'(hostGnt),    32'(host_go));
        check("cpuRvalid",  32'(cpuRvalid),  32'(rv_c));
        check("hostRvalid", 32'(hostRvalid), 32'(rv_h));
        check("cpuStall",   32'(cpuStall),   32'(e_stall));
        check("cpuRdata",   32'(cpuRdata),   32'(e_rc));
        check("hostRdata",  32'(hostRdata),  32'(e_rh));
        if (host_go) begin
            check("ramWe_host",    32'(ramWe),    32'(hw));
            check("ramAddr_host",  32'(ramAddr),  32'(ha));
            check("ramWdata_host", 32'(ramWdata), 32'(hd));
        end else if (cpu_go) begin
            check("ramWe_cpu",    32'(ramWe),    32'(cw));
            check("ramAddr_cpu",  32'(ramAddr),  32'(ca));
            check("ramWdata_cpu", 32'(ramWdata), 32'(cd));
        end

        cpu_done  = (cpu_go && cw) || rv_c;
        host_done = host_go;
        if (rst) begin
            m_busy = 0; m_starve = 0; m_last_c = '0; m_last_h = '0;
        end else begin
            if (rv_c) begin m_last_c = e_rc; m_busy = 0; end
            if (rv_h) begin m_last_h = e_rh; m_busy = 0; end
            if (host_go) begin
                if (hw) golden[ha] = hd;
                else begin m_busy = 1; m_rd_host = 1; m_rd_addr = ha; m_done_cyc = cyc + RL; end
            end else if (cpu_go) begin
                if (cw) golden[ca] = cd;
                else begin m_busy = 1; m_rd_host = 0; m_rd_addr = ca; m_done_cyc = cyc + RL; end
            end
            if (host_go || !hr) m_starve = 0;
            else if (cpu_go) m_starve = (m_starve + 1 > MW) ? MW : m_starve + 1;
        end
        if (cpu_done) cr = 0;
        if (host_done) hr = 0;
        cyc++;
    endtask

    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int n);
        cr = 1; cw = we; ca = a; cd = d; n = 0;
        do begin step(); n++; end while (!cpu_done && n < 50);
        check("cpu_op_done", 32'(cpu_done), 32'd1);
    endtask

    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int n);
        hr = 1; hw = we; ha = a; hd = d; n = 0;
        do begin step(); n++; end while (!host_done && n < 50);
        check("host_op_done", 32'(host_done), 32'd1);
    endtask

    initial begin
        int n;
        int gnt_at;
        cyc = 0; m_busy = 0; m_rd_host = 0; m_done_cyc = 0; m_rd_addr = '0;
        m_starve = 0; m_last_c = '0; m_last_h = '0; cpu_done = 0; host_done = 0;
        rst = 1; cr = 0; cw = 0; ca = '0; cd = '0; hr = 0; hw = 0; ha = '0; hd = '0;

        // Reset then quiet idle.
        repeat (2) step();
        rst = 0;
        repeat (5) step();

        // CPU write then read-back of the same word.
        cpu_op(1, 10'h010, 24'hABCDEF, n);
        check("cpu_wr_cycles", 32'(n), 32'd1);
        cpu_op(0, 10'h010, '0, n);
        check("cpu_rd_cycles", 32'(n), 32'(RL + 1));

        // Host loader fills words 0..15; every request granted at once.
        for (int i = 0; i < 16; i++) begin
            host_op(1, AW'(i), (i < 4) ? DW'(i + 1) : DW'($urandom), n);
            check("host_wr_gnt_cycles", 32'(n), 32'd1);
        end

        // CPU streams writes while the host waits; host wins after MW overtakes.
        gnt_at = -1;
        hr = 1; hw = 1; ha = 10'h030; hd = 24'h5A5A5A;
        cr = 1; cw = 1; ca = 10'h020; cd = DW'($urandom);
        for (int k = 0; k < 10; k++) begin
            step();
            if (host_done && gnt_at < 0) gnt_at = k;
            if (!cr) begin cr = 1; cw = 1; ca = AW'(10'h020 + k + 1); cd = DW'($urandom); end
        end
        cr = 0;
        check("starve_gnt_cycle", 32'(gnt_at), 32'(MW));
        step();

        // Host read in flight; CPU read must wait until after hostRvalid.
        host_op(0, 10'h002, '0, n);
        cpu_op(0, 10'h003, '0, n);
        check("cpu_after_host_rd", 32'(n), 32'(2 * RL + 1));

        // Reset in the middle of a CPU read, then the same read again.
        cr = 1; cw = 0; ca = 10'h010;
        repeat (2) step();
        rst = 1;
        step();
        rst = 0;
        n = 0;
        do begin step(); n++; end while (!cpu_done && n < 50);
        check("read_after_reset", 32'(cpu_done), 32'd1);

        // Randomized traffic on the filled region, with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            if (!cr && ($urandom % 3 == 0)) begin
                cr = 1; cw = 1'($urandom % 2); ca = AW'($urandom % 16); cd = DW'($urandom);
            end
            if (!hr && ($urandom % 4 == 0)) begin
                hr = 1; hw = 1'($urandom % 2); ha = AW'($urandom % 16); hd = DW'($urandom);
            end
            rst = ($urandom % 250 == 0);
            step();
        end
        rst = 0; cr = 0; hr = 0;
        repeat (RL + 2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 24-bit data RAM between the pipeline memory stage (CPU port) and a host/loader port.
- Grants one access per issue slot.
- Sequences reads through the RAM's fixed read latency.
- Stalls the memory stage while its access is pending.
- Sits between memoryStage and the data RAM; the host port is used for program/data loading and debug.

Parameters:
DATA_W, 24, data word width.
ADDR_W, 10, word address width.
READ_LAT, 1, RAM cycles from ramEn (read) to valid ramRdata; legal 1..4.
MAX_WAIT, 4, consecutive CPU grants a waiting host tolerates before it takes priority; legal 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
cpuReq  in  1  memory stage requests an access; held until completed.
cpuWe  in  1  1 = write, 0 = read.
cpuAddr  in  ADDR_W  CPU word address.
cpuWdata  in  DATA_W  CPU write data.
cpuStall  out  1  hold memory stage.
cpuRvalid  out  1  one-cycle pulse; cpuRdata valid.
cpuRdata  out  DATA_W  CPU read data.
hostReq  in  1  host request; held until hostGnt.
hostWe  in  1  host write enable.
hostAddr  in  ADDR_W  host word address.
hostWdata  in  DATA_W  host write data.
hostGnt  out  1  one-cycle pulse; host request accepted this cycle.
hostRvalid  out  1  one-cycle pulse; hostRdata valid.
hostRdata  out  DATA_W  host read data.
ramEn  out  1  RAM access strobe.
ramWe  out  1  RAM write enable.
ramAddr  out  ADDR_W  RAM address.
ramWdata  out  DATA_W  RAM write data.
ramRdata  in  DATA_W  RAM read data, valid READ_LAT cycles after a read strobe.

Behaviour:
- Reset:
  - State IDLE; waitCnt = 0; owner = CPU.
  - All outputs 0, except cpuStall = cpuReq (combinational).
  - Reset during READ_WAIT drops the read: no rvalid is produced.
- States:
  - IDLE: issue slot available.
  - READ_WAIT: read outstanding; latCnt counts READ_LAT..1; no new issue.
- Arbitration in IDLE:
  - Host wins if hostReq && (!cpuReq || waitCnt == MAX_WAIT). Otherwise CPU wins if cpuReq. Else no issue.
- Issue cycle (combinational outputs):
  - ramEn = 1; ramWe/ramAddr/ramWdata taken from the winner.
  - Host winner: hostGnt = 1.
  - Write: completes in the issue cycle; state stays IDLE. A CPU write sees cpuStall = 0 in that cycle.
  - Read: state -> READ_WAIT; latCnt = READ_LAT; owner is registered.
- READ_WAIT:
  - latCnt decrements each cycle.
  - In the cycle where ramRdata is valid (READ_LAT cycles after issue), the owner's rvalid = 1 and its rdata = ramRdata, both combinational pass-through; state -> IDLE.
  - The next issue is the following cycle, so minimum read occupancy is READ_LAT+1 cycles.
  - Non-owner rdata holds its last value.
- cpuStall = cpuReq && !(CPU write issued this cycle || cpuRvalid this cycle).
  - Stall is high during a CPU read issue and all of READ_WAIT, and low in the cpuRvalid cycle.
  - Stall is high while the host owns the RAM.
- waitCnt (4-bit):
  - Cleared when a host grant occurs or hostReq = 0.
  - Incremented, saturating at MAX_WAIT, on each CPU issue while hostReq = 1.
  - Unchanged otherwise.
- Simultaneous cpuReq and hostReq with waitCnt < MAX_WAIT: CPU wins.
- cpuReq dropping while not granted: no access occurs. Requesters must not change request fields while waiting.
- Address wrap is not applicable; addresses pass through unmodified at ADDR_W bits.

Decomposition:
- Package mem_arb_pkg: typedef enum arb_state_t {IDLE, READ_WAIT}; typedef enum owner_t {OWN_CPU, OWN_HOST}; constant DATA_W_DEF = 24.
- One sub-module, arb_starve_counter: owns waitCnt and drives the hostPriority flag.

Test Plan:
- Reset, then idle with all requests low for 5 cycles -> ramEn = 0, cpuStall = 0, no rvalid or gnt pulses.
- CPU write addr 0x010, data 0xABCDEF -> ramEn = ramWe = 1 with addr 0x010 and data 0xABCDEF in the same cycle; cpuStall = 0. CPU read of 0x010 with READ_LAT = 2 -> cpuStall high for 2 cycles, then cpuRvalid = 1 with cpuRdata = 0xABCDEF.
- Host-only writes of 0x000001..0x000004 to addrs 0..3 -> hostGnt pulses on 4 consecutive cycles; RAM writes in order.
- cpuReq and hostReq both held, CPU issuing back-to-back writes, MAX_WAIT = 4 -> 4 CPU grants, then hostGnt with cpuStall = 1 that cycle, then CPU resumes and waitCnt = 0.
- Host read outstanding while cpuReq rises -> CPU not issued until the cycle after hostRvalid; cpuRvalid never pulses for the host data.
- Reset asserted during READ_WAIT of a CPU read -> no cpuRvalid; state IDLE on the next cycle; a subsequent read completes normally.
